multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore FSM sequencing a multi-cycle LEGv8 datapath: single shared ALU, instruction register (IR), variable-latency data memory.
- Takes the IR opcode field and the ALU Zero flag; produces every datapath enable and select per step.
- Counts retired instructions.
- Halts on HLT or on a data-memory timeout.
- Sits beside the datapath; replaces the single-cycle combinational control decode.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 15: maximum cycles to wait for MemReady in a memory state; must be at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Opcode  in  11  IR[31:21]; stable from DECODE until the next FETCH.
- Zero  in  1  ALU zero flag, valid in the same cycle as the ALU operands.
- MemReady  in  1  data-memory completion strobe.
- PCWrite  out  1  PC load enable.
- PCSrc  out  1  0 = PC+4, 1 = branch target.
- IRWrite  out  1  IR load enable.
- Reg2Loc  out  1  register read port 2 select: 0 = Rm, 1 = Rt.
- ALUSrc  out  1  ALU B input: 0 = register, 1 = sign-extended immediate.
- ALUOp  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 PassB.
- MemRead  out  1  data-memory read.
- MemWrite  out  1  data-memory write.
- MemtoReg  out  1  write-back select: 0 = ALU result, 1 = memory data.
- RegWrite  out  1  register-file write enable.
- Halted  out  1  high in the HALT state.
- MemFault  out  1  sticky; set on memory timeout.
- IllegalOp  out  1  one-cycle pulse on an undecodable opcode.
- InstrCount  out  CNT_W  number of retired instructions.
- State  out  4  current state encoding, for debug.

Behaviour:
- Reset (asynchronous): state = FETCH, opcode-class register = 0, wait counter = 0, InstrCount = 0, MemFault = 0. All outputs are 0 while Reset is high. The first FETCH cycle follows the first rising edge after deassertion. Reset mid-instruction abandons the instruction and does not count it.
- Outputs are decoded from the registered state only. Any output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, EXEC 2, WB_ALU 3, ADDR 4, MEM_RD 5, WB_MEM 6, MEM_WR 7, CBZ 8, BR 9, HALT 10.
- FETCH: IRWrite = 1, PCWrite = 1, PCSrc = 0. Next state DECODE.
- DECODE: no enables asserted. Classifies Opcode and registers the class. Next state by class:
  - ADD/SUB/AND/OR (10001011000, 11001011000, 10001010000, 10101010000) -> EXEC.
  - ADDI/SUBI (1001000100x, 1101000100x) -> EXEC.
  - LDUR (11111000010) or STUR (11111000000) -> ADDR.
  - CBZ (10110100xxx) -> CBZ.
  - B (000101xxxxx) -> BR.
  - HLT (11010100010) -> HALT.
  - Any other opcode -> FETCH with IllegalOp = 1 for one cycle; not counted.
- EXEC:
  - R-type: ALUSrc = 0, Reg2Loc = 0, ALUOp per op.
  - I-type: ALUSrc = 1, ALUOp 000 for ADDI, 001 for SUBI.
  - Next state WB_ALU.
- WB_ALU: RegWrite = 1, MemtoReg = 0, ALUOp and ALUSrc held from EXEC. Next state FETCH; InstrCount += 1.
- ADDR: ALUSrc = 1, ALUOp = 000. Reg2Loc = 1 if STUR. Next state MEM_WR for STUR, MEM_RD for LDUR.
- MEM_RD: MemRead = 1; address controls held. Stay until MemReady = 1, then -> WB_MEM.
- WB_MEM: MemRead = 1, MemtoReg = 1, RegWrite = 1. Next state FETCH; count += 1.
- MEM_WR: MemWrite = 1, Reg2Loc = 1; address controls held. Stay until MemReady = 1, then -> FETCH; count += 1.
- CBZ: Reg2Loc = 1, ALUSrc = 0, ALUOp = 100, PCSrc = 1, PCWrite = Zero (this one output is combinational from Zero). Next state FETCH; count += 1 whether taken or not.
- BR: PCSrc = 1, PCWrite = 1. Next state FETCH; count += 1.
- Memory timeout:
  - The wait counter clears on entry to MEM_RD/MEM_WR and increments each cycle MemReady = 0.
  - When the counter reaches MEM_TIMEOUT with MemReady still 0: MemFault set, next state HALT, instruction not counted.
  - MemReady in the same cycle the timeout is reached wins: normal completion, no fault.
- HALT: Halted = 1; all other enables 0. Exited only by Reset.
- InstrCount wraps modulo 2^CNT_W.
- The branch-target adder uses the IR-associated PC held by the datapath, not the PC incremented in FETCH.
- Latencies (cycles, FETCH to next FETCH): R/I = 4; LDUR = 5 + w; STUR = 4 + w; CBZ = 3; B = 3. Here w is the number of MemReady-low cycles.

Test Plan:
- ADD opcode 10001011000, MemReady tied 1: State sequence 0,1,2,3,0. RegWrite high only in state 3. ALUOp = 000 in states 2-3. InstrCount 0 -> 1.
- LDUR with MemReady low 3 cycles: State 0,1,4,5,5,5,5,6,0 (9 cycles). MemRead high in the five state-5 and state-6 cycles. MemtoReg = 1 and RegWrite = 1 in state 6 only.
- CBZ with Zero = 1, then CBZ with Zero = 0: PCWrite = PCSrc = 1 in state 8 for the first. PCWrite = 0, PCSrc = 1 for the second. InstrCount increments by 2.
- STUR with MemReady held 0, MEM_TIMEOUT = 15: after 15 wait cycles, MemFault = 1, Halted = 1, State = 10, MemWrite = 0, InstrCount unchanged. State stays 10 until Reset.
- Opcode 11111111111: IllegalOp pulses for one cycle in DECODE, next State = 0, InstrCount unchanged. Then HLT 11010100010 gives State 10.
- Reset asserted mid-MEM_RD (asynchronous, between edges): all outputs 0 immediately, InstrCount = 0. After release, the first edge enters FETCH with IRWrite = 1.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// ============================================================================
// multicycle_control_unit_if : datapath <-> control-unit signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      Opcode;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             PCSrc;
  logic             IRWrite;
  logic             Reg2Loc;
  logic             ALUSrc;
  logic [2:0]       ALUOp;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             Halted;
  logic             MemFault;
  logic             IllegalOp;
  logic [CNT_W-1:0] InstrCount;
  logic [3:0]       State;

  // master = control unit, slave = datapath side
  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrc, ALUOp, MemRead, MemWrite,
           MemtoReg, RegWrite, Halted, MemFault, IllegalOp, InstrCount, State
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrc, ALUOp, MemRead, MemWrite,
           MemtoReg, RegWrite, Halted, MemFault, IllegalOp, InstrCount, State
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit : Moore FSM sequencing a multi-cycle LEGv8 datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input wire logic                   clk,
  input wire logic                   Reset,
  multicycle_control_unit_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_WB_ALU = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_MEM = 4'd6,
    S_MEM_WR = 4'd7,
    S_CBZ    = 4'd8,
    S_BR     = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    C_NONE = 4'd0,
    C_ADD  = 4'd1,
    C_SUB  = 4'd2,
    C_AND  = 4'd3,
    C_ORR  = 4'd4,
    C_ADDI = 4'd5,
    C_SUBI = 4'd6,
    C_LDUR = 4'd7,
    C_STUR = 4'd8,
    C_CBZ  = 4'd9,
    C_B    = 4'd10,
    C_HLT  = 4'd11,
    C_ILL  = 4'd12
  } cls_t;

  localparam int                WAIT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  function automatic cls_t classify(input logic [10:0] op);
    cls_t c;
    casez (op)
      11'b10001011000: c = C_ADD;
      11'b11001011000: c = C_SUB;
      11'b10001010000: c = C_AND;
      11'b10101010000: c = C_ORR;
      11'b1001000100?: c = C_ADDI;
      11'b1101000100?: c = C_SUBI;
      11'b11111000010: c = C_LDUR;
      11'b11111000000: c = C_STUR;
      11'b10110100???: c = C_CBZ;
      11'b000101?????: c = C_B;
      11'b11010100010: c = C_HLT;
      default:         c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_op_of(input cls_t c);
    logic [2:0] a;
    case (c)
      C_SUB, C_SUBI: a = ALU_SUB;
      C_AND:         a = ALU_AND;
      C_ORR:         a = ALU_OR;
      default:       a = ALU_ADD;
    endcase
    return a;
  endfunction

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fault_q, fault_d;
  // run_q holds the unit idle until the first edge after reset release
  logic              run_q;
  cls_t              dec_cls;
  logic              retire;
  logic              is_itype;

  assign dec_cls  = classify(bus.Opcode);
  assign is_itype = (cls_q == C_ADDI) || (cls_q == C_SUBI);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      wait_q  <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      fault_q <= fault_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    retire  = 1'b0;
    if (!run_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          cls_d = dec_cls;
          case (dec_cls)
            C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI: state_d = S_EXEC;
            C_LDUR, C_STUR:                             state_d = S_ADDR;
            C_CBZ:                                      state_d = S_CBZ;
            C_B:                                        state_d = S_BR;
            C_HLT:                                      state_d = S_HALT;
            default:                                    state_d = S_FETCH;
          endcase
        end
        S_EXEC:   state_d = S_WB_ALU;
        S_WB_ALU: begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
        S_ADDR: begin
          state_d = (cls_q == C_STUR) ? S_MEM_WR : S_MEM_RD;
          wait_d  = '0;
        end
        S_MEM_RD, S_MEM_WR: begin
          // A ready strobe on the last permitted cycle still completes normally
          if (bus.MemReady) begin
            state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
            retire  = (state_q == S_MEM_WR);
          end else if (wait_q == TIMEOUT_LAST) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_WB_MEM, S_CBZ, S_BR: begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_FETCH;
      endcase
    end
    count_d = retire ? (count_q + CNT_W'(1)) : count_q;
  end

  logic       pc_write, pc_src, ir_write, reg2loc, alu_src;
  logic [2:0] alu_op;
  logic       mem_read, mem_write, mem_to_reg, reg_write, halted, illegal_op;

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        S_DECODE: illegal_op = (dec_cls == C_ILL);
        S_EXEC: begin
          alu_src = is_itype;
          alu_op  = alu_op_of(cls_q);
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          alu_src   = is_itype;
          alu_op    = alu_op_of(cls_q);
        end
        S_ADDR: begin
          alu_src = 1'b1;
          reg2loc = (cls_q == C_STUR);
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          alu_src  = 1'b1;
        end
        S_WB_MEM: begin
          mem_read   = 1'b1;
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          reg2loc   = 1'b1;
          alu_src   = 1'b1;
        end
        S_CBZ: begin
          reg2loc  = 1'b1;
          alu_op   = ALU_PASSB;
          pc_src   = 1'b1;
          pc_write = bus.Zero;
        end
        S_BR: begin
          pc_src   = 1'b1;
          pc_write = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.PCSrc      = pc_src;
  assign bus.IRWrite    = ir_write;
  assign bus.Reg2Loc    = reg2loc;
  assign bus.ALUSrc     = alu_src;
  assign bus.ALUOp      = alu_op;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.RegWrite   = reg_write;
  assign bus.Halted     = halted;
  assign bus.MemFault   = fault_q;
  assign bus.IllegalOp  = illegal_op;
  assign bus.InstrCount = count_q;
  assign bus.State      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// tb_multicycle_control_unit : random instruction stream vs. per-instruction model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 15;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_ADDI = 4, K_SUBI = 5;
  localparam int K_LDUR = 6, K_STUR = 7, K_CBZ = 8, K_B = 9, K_ILL = 10, K_HLT = 11;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(CNT_W)) bus();

  multicycle_control_unit #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;
  logic exp_mf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [10:0] op);
    return op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 ||
           op == 11'b10101010000 || op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100 ||
           op == 11'b11111000010 || op == 11'b11111000000 || op[10:3] == 8'b10110100 ||
           op[10:5] == 6'b000101 || op == 11'b11010100010;
  endfunction

  function automatic logic [10:0] make_op(input int k);
    logic [10:0] op;
    logic [4:0]  r;
    r = 5'($urandom);
    case (k)
      K_ADD:   op = 11'b10001011000;
      K_SUB:   op = 11'b11001011000;
      K_AND:   op = 11'b10001010000;
      K_ORR:   op = 11'b10101010000;
      K_ADDI:  op = {10'b1001000100, r[0]};
      K_SUBI:  op = {10'b1101000100, r[0]};
      K_LDUR:  op = 11'b11111000010;
      K_STUR:  op = 11'b11111000000;
      K_CBZ:   op = {8'b10110100, r[2:0]};
      K_B:     op = {6'b000101, r};
      K_HLT:   op = 11'b11010100010;
      default: begin
        op = 11'($urandom);
        while (is_legal(op)) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  // Expected control word for one cycle, straight from the per-state output table
  function automatic logic [14:0] exp_ctrl(input int st, input int k, input logic z, input logic mf);
    logic pcw, pcs, irw, r2l, asrc, mr, mw, m2r, rw, hl, il;
    logic [2:0] aop, arith;
    logic itype;
    {pcw, pcs, irw, r2l, asrc, mr, mw, m2r, rw, hl, il} = '0;
    aop   = 3'b000;
    itype = (k == K_ADDI) || (k == K_SUBI);
    arith = (k == K_SUB || k == K_SUBI) ? 3'b001 : (k == K_AND) ? 3'b010 :
            (k == K_ORR) ? 3'b011 : 3'b000;
    case (st)
      0:  begin irw = 1'b1; pcw = 1'b1; end
      1:  il = (k == K_ILL);
      2:  begin asrc = itype; aop = arith; end
      3:  begin rw = 1'b1; asrc = itype; aop = arith; end
      4:  begin asrc = 1'b1; r2l = (k == K_STUR); end
      5:  begin mr = 1'b1; asrc = 1'b1; end
      6:  begin mr = 1'b1; m2r = 1'b1; rw = 1'b1; end
      7:  begin mw = 1'b1; r2l = 1'b1; asrc = 1'b1; end
      8:  begin r2l = 1'b1; aop = 3'b100; pcs = 1'b1; pcw = z; end
      9:  begin pcs = 1'b1; pcw = 1'b1; end
      10: hl = 1'b1;
      default: ;
    endcase
    return {pcw, pcs, irw, r2l, asrc, aop, mr, mw, m2r, rw, hl, mf, il};
  endfunction

  function automatic logic [14:0] obs_ctrl();
    return {bus.PCWrite, bus.PCSrc, bus.IRWrite, bus.Reg2Loc, bus.ALUSrc, bus.ALUOp,
            bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite, bus.Halted,
            bus.MemFault, bus.IllegalOp};
  endfunction

  // Called between clock edges; returns just after the first FETCH edge
  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #1;
    exp_count = 0;
    exp_mf    = 1'b0;
    check({tag, "/rst_ctrl"},  32'(obs_ctrl()), 32'h0);
    check({tag, "/rst_state"}, 32'(bus.State), 32'h0);
    check({tag, "/rst_count"}, 32'(bus.InstrCount), 32'h0);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    @(negedge clk);
    check({tag, "/rel_ctrl"},  32'(obs_ctrl()), 32'h0);
    check({tag, "/rel_state"}, 32'(bus.State), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int n, input int k, input logic [10:0] op, input int w,
                           input int zmode, input bit do_abort);
    int seq[$];
    int nmem, abort_at, j;
    logic tmo, z;
    string tag;
    tmo = (k == K_LDUR || k == K_STUR) && (w >= MEM_TIMEOUT);
    nmem = tmo ? MEM_TIMEOUT : w + 1;
    seq.push_back(0);
    seq.push_back(1);
    case (k)
      K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI: begin seq.push_back(2); seq.push_back(3); end
      K_LDUR: begin
        seq.push_back(4);
        for (int i = 0; i < nmem; i++) seq.push_back(5);
        if (!tmo) seq.push_back(6);
      end
      K_STUR: begin
        seq.push_back(4);
        for (int i = 0; i < nmem; i++) seq.push_back(7);
      end
      K_CBZ: seq.push_back(8);
      K_B:   seq.push_back(9);
      default: ;
    endcase
    if (tmo || k == K_HLT) for (int i = 0; i < 3; i++) seq.push_back(10);
    abort_at = do_abort ? $urandom_range(0, seq.size() - 1) : -1;
    j = 0;
    for (int i = 0; i < seq.size(); i++) begin
      tag = $sformatf("i%0d/k%0d/c%0d", n, k, i);
      bus.Opcode = op;
      z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      bus.Zero = z;
      if (seq[i] == 5 || seq[i] == 7) begin
        bus.MemReady = (j >= w);
        j++;
      end else begin
        bus.MemReady = 1'($urandom);
      end
      if (seq[i] == 10 && tmo) exp_mf = 1'b1;
      @(negedge clk);
      check({tag, "/state"}, 32'(bus.State), 32'(seq[i]));
      check({tag, "/ctrl"},  32'(obs_ctrl()), 32'(exp_ctrl(seq[i], k, z, exp_mf)));
      check({tag, "/count"}, 32'(bus.InstrCount), 32'(exp_count));
      if (i == abort_at) begin
        do_reset({tag, "/abort"});
        return;
      end
      @(posedge clk);
      #1;
    end
    if (tmo || k == K_HLT) do_reset(tag);
    else if (k != K_ILL) exp_count = (exp_count + 1) % (1 << CNT_W);
  endtask

  initial begin
    int k, w, r;
    Reset        = 1'b1;
    bus.Opcode   = '0;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b0;
    #1;
    do_reset("init");

    run_instr(0, K_ADD,  11'b10001011000, 0, 0, 1'b0);
    run_instr(1, K_LDUR, 11'b11111000010, 3, 0, 1'b0);
    run_instr(2, K_CBZ,  11'b10110100000, 0, 1, 1'b0);
    run_instr(3, K_CBZ,  11'b10110100000, 0, 0, 1'b0);
    run_instr(4, K_ILL,  11'b11111111111, 0, 0, 1'b0);
    run_instr(5, K_HLT,  11'b11010100010, 0, 0, 1'b0);
    run_instr(6, K_STUR, 11'b11111000000, MEM_TIMEOUT + 4, 0, 1'b0);
    run_instr(7, K_LDUR, 11'b11111000010, MEM_TIMEOUT - 1, 0, 1'b0);
    run_instr(8, K_LDUR, 11'b11111000010, 5, 0, 1'b1);

    for (int n = 9; n < 260; n++) begin
      r = $urandom_range(0, 99);
      k = (r < 3) ? K_HLT : $urandom_range(K_ADD, K_ILL);
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(MEM_TIMEOUT, MEM_TIMEOUT + 4)
                                      : $urandom_range(0, 6);
      run_instr(n, k, make_op(k), w, 2, $urandom_range(0, 14) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
